// File: rtl/uart_rx_buf.sv
// uart_rx_buf: buffered 8N1 UART receiver.
// The rx line is synchronised and framed with mid-bit sampling. Good bytes
// land in a small FIFO that is drained through rdreq/q/empty/full. Framing
// errors and dropped bytes are reported on sticky flags, which clr clears.

module uart_rx_buf #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600,
    parameter int DEPTH    = 8
) (
    input  logic       clk,
    input  logic       rst,        // asynchronous, active low
    input  logic       rx,
    input  logic       rdreq,
    input  logic       clr,
    output logic [7:0] q,
    output logic       empty,
    output logic       full,
    output logic       irq,
    output logic       frame_err,
    output logic       overrun
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int BIT_CNT = CLK_FREQ / BAUD;
    localparam int TW      = $clog2(BIT_CNT + 1);
    localparam int AW      = $clog2(DEPTH);
    localparam int PW      = AW + 1;

    // The timer counts down. A value loaded with N-1 expires N cycles later,
    // which places every sample exactly N edges after the previous reload.
    localparam logic [TW-1:0] BIT_LOAD  = TW'(BIT_CNT - 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'((BIT_CNT / 2) - 1);
    localparam logic [TW-1:0] T_ZERO    = {TW{1'b0}};
    localparam logic [TW-1:0] T_ONE     = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PTR_ZERO  = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic          rx_meta_r;     // first synchroniser stage
    logic          rx_sync_r;     // second synchroniser stage (rxs)
    logic          rx_prev_r;     // rxs one cycle ago, for falling-edge detect
    state_t        state_r;
    logic [TW-1:0] timer_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic [7:0]    mem_r [DEPTH];
    logic [PW-1:0] wptr_r;
    logic [PW-1:0] rptr_r;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic          tick_s;        // bit timer has expired this cycle
    logic          start_s;       // falling edge on rxs while idle
    logic          push_s;        // stop bit good: byte is ready to store
    logic          fe_set_s;      // stop bit low: framing error event
    logic          pop_s;         // accepted read
    logic          wr_ok_s;       // byte actually written into the FIFO
    logic          drop_s;        // byte lost to a full FIFO
    logic [PW-1:0] wptr_nxt_s;
    logic [PW-1:0] rptr_nxt_s;

    // Decode start/stop events and the FIFO push/pop decisions.
    always_comb begin
        tick_s     = 1'b0;
        start_s    = 1'b0;
        push_s     = 1'b0;
        fe_set_s   = 1'b0;
        pop_s      = 1'b0;
        wr_ok_s    = 1'b0;
        drop_s     = 1'b0;
        wptr_nxt_s = wptr_r;
        rptr_nxt_s = rptr_r;

        tick_s = (timer_r == T_ZERO);

        if (state_r == ST_IDLE) begin
            start_s = rx_prev_r & ~rx_sync_r;
        end else begin
            start_s = 1'b0;
        end

        if ((state_r == ST_STOP) && tick_s) begin
            push_s   = rx_sync_r;
            fe_set_s = ~rx_sync_r;
        end else begin
            push_s   = 1'b0;
            fe_set_s = 1'b0;
        end

        pop_s = rdreq & ~empty;

        // A pop on the same edge frees the slot the push needs, so a full
        // FIFO still accepts the byte in that case.
        if (push_s) begin
            if (!full || pop_s) begin
                wr_ok_s = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            wr_ok_s = 1'b0;
            drop_s  = 1'b0;
        end

        if (wr_ok_s) begin
            wptr_nxt_s = wptr_r + PTR_ONE;
        end else begin
            wptr_nxt_s = wptr_r;
        end

        if (pop_s) begin
            rptr_nxt_s = rptr_r + PTR_ONE;
        end else begin
            rptr_nxt_s = rptr_r;
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Two-flop synchroniser plus history flop; idle-high reset avoids a false start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Receive framing FSM with a shared bit timer reloaded on each sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            timer_r   <= T_ZERO;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r <= ST_START;
                        timer_r <= HALF_LOAD;
                    end else begin
                        timer_r <= T_ZERO;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        if (!rx_sync_r) begin
                            state_r   <= ST_DATA;
                            bit_idx_r <= 3'd0;
                            timer_r   <= BIT_LOAD;
                        end else begin
                            // Line went back high before mid-bit: a glitch.
                            state_r <= ST_IDLE;
                            timer_r <= T_ZERO;
                        end
                    end else begin
                        timer_r <= timer_r - T_ONE;
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        shift_r <= {rx_sync_r, shift_r[7:1]};
                        timer_r <= BIT_LOAD;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        timer_r <= timer_r - T_ONE;
                    end
                end
                ST_STOP: begin
                    if (tick_s) begin
                        timer_r <= T_ZERO;
                        if (rx_sync_r) begin
                            state_r <= ST_IDLE;
                        end else begin
                            // Hold off until the line recovers so a long
                            // low (break) yields only one framing error.
                            state_r <= ST_BREAK;
                        end
                    end else begin
                        timer_r <= timer_r - T_ONE;
                    end
                end
                ST_BREAK: begin
                    timer_r <= T_ZERO;
                    if (rx_sync_r) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_BREAK;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    timer_r   <= T_ZERO;
                    bit_idx_r <= 3'd0;
                end
            endcase
        end
    end

    // FIFO storage: write the completed byte at the write pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else begin
            if (wr_ok_s) begin
                mem_r[wptr_r[AW-1:0]] <= shift_r;
            end
        end
    end

    // FIFO pointers, registered status flags, read data and push strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_r <= PTR_ZERO;
            rptr_r <= PTR_ZERO;
            q      <= 8'h00;
            empty  <= 1'b1;
            full   <= 1'b0;
            irq    <= 1'b0;
        end else begin
            wptr_r <= wptr_nxt_s;
            rptr_r <= rptr_nxt_s;
            // Flags are computed from the next pointers so they are
            // correct on the cycle after every push or pop.
            empty  <= (wptr_nxt_s == rptr_nxt_s);
            full   <= (wptr_nxt_s[AW] != rptr_nxt_s[AW]) &&
                      (wptr_nxt_s[AW-1:0] == rptr_nxt_s[AW-1:0]);
            irq    <= wr_ok_s;
            if (pop_s) begin
                // Reads the old slot contents even if a write hits the
                // same slot on this edge, so the oldest byte comes out.
                q <= mem_r[rptr_r[AW-1:0]];
            end
        end
    end

    // Sticky error flags; a new error event wins over a coincident clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (fe_set_s) begin
                frame_err <= 1'b1;
            end else if (clr) begin
                frame_err <= 1'b0;
            end
            if (drop_s) begin
                overrun <= 1'b1;
            end else if (clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_buf.sv
// tb_uart_rx_buf: directed bench for the buffered UART receiver.
// BIT_CNT = 10 and DEPTH = 4. Serial frames are driven on falling clock
// edges and all outputs are observed on falling edges.

module tb_uart_rx_buf;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 5_000_000;
    localparam int DEPTH    = 4;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       rx    = 1'b1;
    logic       rdreq = 1'b0;
    logic       clr   = 1'b0;
    logic [7:0] q;
    logic       empty;
    logic       full;
    logic       irq;
    logic       frame_err;
    logic       overrun;

    int   cmp_cnt   = 0;
    int   err_cnt   = 0;
    int   irq_cnt   = 0;
    int   irq_wide  = 0;
    logic irq_prev  = 1'b0;
    int   c0;
    logic [7:0] v;

    uart_rx_buf #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rdreq     (rdreq),
        .clr       (clr),
        .q         (q),
        .empty     (empty),
        .full      (full),
        .irq       (irq),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Count irq pulses and catch any pulse longer than one cycle.
    always @(negedge clk) begin
        if (irq) irq_cnt++;
        if (irq && irq_prev) irq_wide++;
        irq_prev = irq;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame, 10 clocks per bit. rdreq is pulsed for one cycle at
    // step rd_at (step 0 is the start-bit fall); -1 means no read.
    task automatic send(input logic [7:0] d, input logic stop_bit, input int rd_at);
        logic [9:0] frame;
        frame = {stop_bit, d, 1'b0};
        @(negedge clk);
        for (int n = 0; n < 100; n++) begin
            rx    = frame[n / 10];
            rdreq = (n == rd_at);
            @(negedge clk);
        end
        rdreq = 1'b0;
        rx    = 1'b1;
    endtask

    // Called on a falling edge; returns q one cycle after rdreq.
    task automatic do_read(output logic [7:0] d);
        rdreq = 1'b1;
        @(negedge clk);
        rdreq = 1'b0;
        d = q;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_q"},     32'(q),         32'h00);
        chk({tag, "_empty"}, 32'(empty),     32'h1);
        chk({tag, "_full"},  32'(full),      32'h0);
        chk({tag, "_irq"},   32'(irq),       32'h0);
        chk({tag, "_ferr"},  32'(frame_err), 32'h0);
        chk({tag, "_ovr"},   32'(overrun),   32'h0);
    endtask

    initial begin
        // Reset state
        idle(3);
        chk_reset_vals("rst");
        rst = 1'b1;
        idle(5);

        // 1: single frame then one read
        c0 = irq_cnt;
        send(8'hA5, 1'b1, -1);
        idle(3);
        chk("s1_irq", 32'(irq_cnt - c0), 32'd1);
        chk("s1_empty_lo", 32'(empty), 32'h0);
        do_read(v);
        chk("s1_q", 32'(v), 32'hA5);
        chk("s1_empty_hi", 32'(empty), 32'h1);

        // 2: fill, overrun on the fifth, drain in order
        c0 = irq_cnt;
        for (int b = 1; b <= 4; b++) send(8'(b), 1'b1, -1);
        idle(3);
        chk("s2_irq4", 32'(irq_cnt - c0), 32'd4);
        chk("s2_full", 32'(full), 32'h1);
        chk("s2_ovr0", 32'(overrun), 32'h0);
        send(8'h05, 1'b1, -1);
        idle(3);
        chk("s2_irq_drop", 32'(irq_cnt - c0), 32'd4);
        chk("s2_ovr1", 32'(overrun), 32'h1);
        chk("s2_full_still", 32'(full), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            do_read(v);
            chk("s2_rd", 32'(v), 32'(i));
        end
        chk("s2_empty", 32'(empty), 32'h1);
        chk("s2_full_lo", 32'(full), 32'h0);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        chk("s2_clr_ovr", 32'(overrun), 32'h0);

        // 3: bad stop bit followed by a held-low line, then a good frame
        c0 = irq_cnt;
        send(8'h3C, 1'b0, -1);
        rx = 1'b0;
        idle(50);
        chk("s3_ferr", 32'(frame_err), 32'h1);
        chk("s3_irq", 32'(irq_cnt - c0), 32'd0);
        chk("s3_empty", 32'(empty), 32'h1);
        chk("s3_ovr", 32'(overrun), 32'h0);
        rx = 1'b1;
        idle(5);
        chk("s3_ferr_sticky", 32'(frame_err), 32'h1);
        send(8'h7E, 1'b1, -1);
        idle(3);
        chk("s3_irq_good", 32'(irq_cnt - c0), 32'd1);
        do_read(v);
        chk("s3_q", 32'(v), 32'h7E);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        chk("s3_clr_ferr", 32'(frame_err), 32'h0);

        // 4: short low glitch on an idle line
        c0 = irq_cnt;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(20);
        chk("s4_irq", 32'(irq_cnt - c0), 32'd0);
        chk("s4_ferr", 32'(frame_err), 32'h0);
        chk("s4_ovr", 32'(overrun), 32'h0);
        chk("s4_empty", 32'(empty), 32'h1);

        // 5: full FIFO, read on the push edge of the fifth frame.
        // Stop sample falls between steps 97 and 98 of the frame.
        c0 = irq_cnt;
        send(8'h11, 1'b1, -1);
        send(8'h22, 1'b1, -1);
        send(8'h33, 1'b1, -1);
        send(8'h44, 1'b1, -1);
        idle(2);
        chk("s5_full_pre", 32'(full), 32'h1);
        send(8'h55, 1'b1, 97);
        idle(3);
        chk("s5_irq", 32'(irq_cnt - c0), 32'd5);
        chk("s5_full", 32'(full), 32'h1);
        chk("s5_ovr", 32'(overrun), 32'h0);
        chk("s5_q_oldest", 32'(q), 32'h11);
        do_read(v);
        chk("s5_rd22", 32'(v), 32'h22);
        do_read(v);
        chk("s5_rd33", 32'(v), 32'h33);
        do_read(v);
        chk("s5_rd44", 32'(v), 32'h44);
        do_read(v);
        chk("s5_rd55", 32'(v), 32'h55);
        chk("s5_empty", 32'(empty), 32'h1);

        // 6: reset in the middle of a frame, with a byte already stored
        send(8'h66, 1'b1, -1);
        idle(3);
        chk("s6_empty_pre", 32'(empty), 32'h0);
        rx = 1'b0;          // start bit of 0xC3
        idle(10);
        rx = 1'b1;          // bit 0
        idle(10);
        rx = 1'b1;          // bit 1
        idle(10);
        rx = 1'b0;          // bit 2, cut short
        idle(5);
        rst = 1'b0;
        idle(2);
        chk_reset_vals("s6_rst");
        rx = 1'b1;
        idle(2);
        rst = 1'b1;
        idle(5);
        chk_reset_vals("s6_post");
        send(8'h99, 1'b1, -1);
        idle(3);
        do_read(v);
        chk("s6_q", 32'(v), 32'h99);
        chk("s6_empty", 32'(empty), 32'h1);
        do_read(v);
        chk("s6_rd_empty_hold", 32'(v), 32'h99);
        chk("s6_empty_hold", 32'(empty), 32'h1);

        chk("irq_width", 32'(irq_wide), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
